axi_stream_skid_buffer: RTL and testbench

// - Full-throughput AXI-Stream register slice (skid buffer) that breaks combinational tready/tvalid/payload paths.
// - Sits directly upstream of any stream consumer. Its master-side output must satisfy every AXI-Stream

---
 rtl/axi_stream_pkg.sv | 17 +
 rtl/axi_stream_skid_buffer.sv | 121 ++++++++++++
 tb/tb_axi_stream_skid_buffer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/axi_stream_pkg.sv
// Shared types for the AXI-Stream skid buffer: control state encoding and the
// width of the packed payload vector.
package axi_stream_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

  // Payload is {tdata, tstrb, tkeep, tlast, tid, tdest, tuser}.
  function automatic int payload_width(input int byte_width, input int id_width,
                                       input int dest_width, input int user_width);
    return 8 * byte_width + byte_width + byte_width + 1 + id_width + dest_width + user_width;
  endfunction

endpackage

// File: rtl/axi_stream_skid_buffer.sv
// Full-throughput AXI-Stream register slice: output register plus one skid
// register, so both tready and tvalid/payload are driven from flops.
//
//   state | meaning
//   EMPTY | no beat held; m_tvalid=0, s_tready=1
//   ONE   | beat in output reg; m_tvalid=1, s_tready=1
//   TWO   | output and skid regs full; m_tvalid=1, s_tready=0
module axi_stream_skid_buffer
  import axi_stream_pkg::*;
#(
  parameter int byte_width = 4,
  parameter int id_width   = 1,
  parameter int dest_width = 1,
  parameter int user_width = 1
) (
  input  logic                    clk,
  input  logic                    resetn,

  input  logic                    s_tvalid,
  output logic                    s_tready,
  input  logic [8*byte_width-1:0] s_tdata,
  input  logic [byte_width-1:0]   s_tstrb,
  input  logic [byte_width-1:0]   s_tkeep,
  input  logic                    s_tlast,
  input  logic [id_width-1:0]     s_tid,
  input  logic [dest_width-1:0]   s_tdest,
  input  logic [user_width-1:0]   s_tuser,

  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic [8*byte_width-1:0] m_tdata,
  output logic [byte_width-1:0]   m_tstrb,
  output logic [byte_width-1:0]   m_tkeep,
  output logic                    m_tlast,
  output logic [id_width-1:0]     m_tid,
  output logic [dest_width-1:0]   m_tdest,
  output logic [user_width-1:0]   m_tuser
);

  localparam int PW = payload_width(byte_width, id_width, dest_width, user_width);

  skid_state_e   state_q, state_d;
  logic          m_tvalid_q;
  logic          s_tready_q;
  logic [PW-1:0] s_payload;
  logic [PW-1:0] out_q;
  logic [PW-1:0] skid_q;
  logic          acc;
  logic          drn;
  logic          load_out_s;
  logic          load_out_skid;
  logic          load_skid;

  assign s_payload = {s_tdata, s_tstrb, s_tkeep, s_tlast, s_tid, s_tdest, s_tuser};

  assign acc = s_tvalid & s_tready_q;
  assign drn = m_tvalid_q & m_tready;

  always_comb begin
    state_d       = state_q;
    load_out_s    = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (acc) begin
          state_d    = ONE;
          load_out_s = 1'b1;
        end
      end
      ONE: begin
        if (acc && drn) begin
          load_out_s = 1'b1;
        end else if (acc) begin
          state_d   = TWO;
          load_skid = 1'b1;
        end else if (drn) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (drn) begin
          state_d       = ONE;
          load_out_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Handshake flags are re-derived from the next state so neither output
  // ever depends combinationally on the opposite side.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= EMPTY;
      m_tvalid_q <= 1'b0;
      s_tready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      m_tvalid_q <= (state_d != EMPTY);
      s_tready_q <= (state_d != TWO);
    end
  end

  // Payload registers carry no reset; their content is qualified by m_tvalid.
  always_ff @(posedge clk) begin
    if (load_out_s) begin
      out_q <= s_payload;
    end else if (load_out_skid) begin
      out_q <= skid_q;
    end
    if (load_skid) begin
      skid_q <= s_payload;
    end
  end

  assign s_tready = s_tready_q;
  assign m_tvalid = m_tvalid_q;
  assign {m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser} = out_q;

endmodule

// File: tb/tb_axi_stream_skid_buffer.sv
// Self-checking bench for axi_stream_skid_buffer: a queue-based occupancy and
// ordering model plus master-side stability checks on every cycle.
module tb_axi_stream_skid_buffer;

  localparam int BW = 4;
  localparam int VW = 8 * BW + BW + BW + 1 + 1 + 1 + 1;

  logic          clk;
  logic          resetn;
  logic          s_tvalid;
  logic          s_tready;
  logic [31:0]   s_tdata;
  logic [3:0]    s_tstrb;
  logic [3:0]    s_tkeep;
  logic          s_tlast;
  logic [0:0]    s_tid;
  logic [0:0]    s_tdest;
  logic [0:0]    s_tuser;
  logic          m_tvalid;
  logic          m_tready;
  logic [31:0]   m_tdata;
  logic [3:0]    m_tstrb;
  logic [3:0]    m_tkeep;
  logic          m_tlast;
  logic [0:0]    m_tid;
  logic [0:0]    m_tdest;
  logic [0:0]    m_tuser;

  logic [VW-1:0] s_vec;
  logic [VW-1:0] m_vec;

  int checks   = 0;
  int failures = 0;

  logic [VW-1:0] model_q[$];
  bit            exp_rdy = 1'b0;
  bit            stall_prev = 1'b0;
  logic [VW-1:0] held;
  int            accepted;

  assign {s_tdata, s_tstrb, s_tkeep, s_tlast, s_tid, s_tdest, s_tuser} = s_vec;
  assign m_vec = {m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser};

  axi_stream_skid_buffer #(
    .byte_width(BW), .id_width(1), .dest_width(1), .user_width(1)
  ) dut (
    .clk(clk), .resetn(resetn),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tstrb(s_tstrb),
    .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tid(s_tid), .s_tdest(s_tdest), .s_tuser(s_tuser),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tstrb(m_tstrb),
    .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tid(m_tid), .m_tdest(m_tdest), .m_tuser(m_tuser)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [VW-1:0] rand_beat(input logic [31:0] data);
    logic [3:0] keep;
    logic [3:0] strb;
    keep = 4'($urandom_range(0, 15));
    strb = 4'($urandom) & keep;
    return {data, strb, keep, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom)};
  endfunction

  // One clock: drive inputs, check outputs against the model at the negedge,
  // then advance the model across the coming rising edge.
  task automatic cycle(input bit rv, input bit sv, input logic [VW-1:0] beat, input bit mr);
    bit exp_valid;
    resetn   = rv;
    s_tvalid = sv;
    s_vec    = beat;
    m_tready = mr;
    @(negedge clk);
    exp_valid = (model_q.size() != 0);
    chk("m_tvalid", 64'(m_tvalid), 64'(exp_valid));
    chk("s_tready", 64'(s_tready), 64'(exp_rdy));
    if (exp_valid) chk("payload", 64'(m_vec), 64'(model_q[0]));
    if (stall_prev) chk("stall_hold", 64'(m_vec), 64'(held));
    stall_prev = rv && exp_valid && !mr;
    held       = m_vec;
    if (!rv) begin
      model_q.delete();
      exp_rdy = 1'b0;
    end else begin
      if (exp_valid && mr) void'(model_q.pop_front());
      if (sv && exp_rdy) begin
        model_q.push_back(beat);
        accepted++;
      end
      exp_rdy = (model_q.size() < 2);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int budget;
    resetn   = 1'b0;
    s_tvalid = 1'b0;
    s_vec    = '0;
    m_tready = 1'b0;
    accepted = 0;
    @(posedge clk);
    #1;

    // Reset held three cycles, then release
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, rand_beat(32'hDEAD), 1'b1);
    cycle(1'b1, 1'b0, '0, 1'b1);
    chk("ready_after_release", 64'(s_tready), 64'd1);

    // Back-to-back streaming
    for (int i = 1; i <= 16; i++) cycle(1'b1, 1'b1, rand_beat(32'(i)), 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0, 1'b1);

    // Stall with two beats
    cycle(1'b1, 1'b1, rand_beat(32'hA), 1'b0);
    cycle(1'b1, 1'b1, rand_beat(32'hB), 1'b0);
    chk("stall_data_a", 64'(m_tdata), 64'hA);
    chk("stall_ready_low", 64'(s_tready), 64'd0);
    cycle(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0, 1'b1);
    chk("stall_ready_back", 64'(s_tready), 64'd1);

    // Random traffic and back-pressure
    accepted = 0;
    budget   = 20000;
    while (accepted < 1000 && budget > 0) begin
      cycle(1'b1, 1'($urandom_range(0, 99) < 70), rand_beat($urandom),
            1'($urandom_range(0, 99) < 60));
      budget--;
    end
    chk("random_budget", 64'(accepted >= 1000), 64'd1);
    budget = 20;
    while (model_q.size() != 0 && budget > 0) begin
      cycle(1'b1, 1'b0, '0, 1'b1);
      budget--;
    end
    chk("drain_empty", 64'(model_q.size()), 64'd0);

    // Reset while both stages are full
    cycle(1'b1, 1'b1, rand_beat(32'hC), 1'b0);
    cycle(1'b1, 1'b1, rand_beat(32'hD), 1'b0);
    chk("two_full_ready", 64'(s_tready), 64'd0);
    cycle(1'b0, 1'b0, '0, 1'b1);
    chk("reset_drop_valid", 64'(m_tvalid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk("no_stale_beat", 64'(m_tvalid), 64'd0);
      cycle(1'b1, 1'b0, '0, 1'b1);
    end
    cycle(1'b1, 1'b1, rand_beat(32'h5A5A), 1'b1);
    cycle(1'b1, 1'b0, '0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
